// File: rtl/mar_access_arbiter_if.sv
// Requester and MAR-side signal bundle for the MAR access arbiter.
// Handshake: a requester raises *_req (with address/length stable) and holds it until *_gnt rises; gnt then stays high for the whole access, and *_valid/dma_done are single-cycle pulses with no back-pressure.
interface mar_access_arbiter_if #(
  parameter int ADDR_W = 16,
  parameter int LEN_W  = 8
);
  logic              cpu_req;
  logic [ADDR_W-1:0] cpu_addr;
  logic              cpu_gnt;
  logic              cpu_valid;
  logic              dma_req;
  logic [ADDR_W-1:0] dma_addr;
  logic [LEN_W-1:0]  dma_len;
  logic              dma_gnt;
  logic              dma_valid;
  logic              dma_done;
  logic [ADDR_W-1:0] mar_data;
  logic              mar_load;
  logic              mar_inc;
  logic              busy;

  modport slave (
    input  cpu_req, cpu_addr, dma_req, dma_addr, dma_len,
    output cpu_gnt, cpu_valid, dma_gnt, dma_valid, dma_done,
           mar_data, mar_load, mar_inc, busy
  );

  modport master (
    output cpu_req, cpu_addr, dma_req, dma_addr, dma_len,
    input  cpu_gnt, cpu_valid, dma_gnt, dma_valid, dma_done,
           mar_data, mar_load, mar_inc, busy
  );
endinterface

// File: rtl/mar_access_arbiter.sv
// Round-robin owner of the shared memory address register: CPU single-word accesses vs DMA bursts.
// Every output is registered; the next-output logic is derived from the next state and counters.
module mar_access_arbiter #(
  parameter int ADDR_W  = 16,
  parameter int LEN_W   = 8,
  parameter int RAM_LAT = 1
) (
  input  logic                 Clk,
  input  logic                 Rst_n,
  mar_access_arbiter_if.slave  bus,
  output logic [1:0]           o_dbg_state
);

  localparam int WAIT_W = (RAM_LAT > 1) ? $clog2(RAM_LAT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_RELOAD = WAIT_W'(RAM_LAT - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_BEAT = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t            r_state, w_state_nx;
  logic [WAIT_W-1:0] r_wait, w_wait_nx;
  logic [LEN_W-1:0]  r_remain, w_remain_nx;
  logic              r_owner_dma, w_owner_nx;
  logic              w_pick_dma;

  logic [ADDR_W-1:0] r_mar_data, w_mar_data_nx;
  logic              r_cpu_gnt, r_cpu_valid, r_dma_gnt, r_dma_valid, r_dma_done;
  logic              r_mar_load, r_mar_inc, r_busy;
  logic              w_fire_nx;

  always_comb begin
    w_state_nx    = r_state;
    w_wait_nx     = r_wait;
    w_remain_nx   = r_remain;
    w_owner_nx    = r_owner_dma;
    w_mar_data_nx = r_mar_data;
    w_pick_dma    = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_mar_data_nx = '0;
        if (bus.cpu_req || bus.dma_req) begin
          // On a tie the requester that did not own the MAR last time wins.
          w_pick_dma    = bus.dma_req && (!bus.cpu_req || !r_owner_dma);
          w_owner_nx    = w_pick_dma;
          w_mar_data_nx = w_pick_dma ? bus.dma_addr : bus.cpu_addr;
          w_remain_nx   = !w_pick_dma ? LEN_W'(1)
                        : (bus.dma_len == '0) ? LEN_W'(1) : bus.dma_len;
          w_state_nx    = S_LOAD;
        end
      end
      S_LOAD: begin
        w_state_nx = S_BEAT;
        w_wait_nx  = WAIT_RELOAD;
      end
      S_BEAT: begin
        if (r_wait != '0) begin
          w_wait_nx = r_wait - WAIT_W'(1);
        end else begin
          w_remain_nx = r_remain - LEN_W'(1);
          if (r_remain == LEN_W'(1)) begin
            w_state_nx = S_DONE;
          end else begin
            w_wait_nx = WAIT_RELOAD;
          end
        end
      end
      S_DONE: begin
        w_state_nx    = S_IDLE;
        w_mar_data_nx = '0;
      end
      default: w_state_nx = S_IDLE;
    endcase
  end

  // A beat completes in the cycle whose wait count is zero; remain still holds the pre-beat count.
  assign w_fire_nx = (w_state_nx == S_BEAT) && (w_wait_nx == '0);

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      r_state     <= S_IDLE;
      r_wait      <= '0;
      r_remain    <= '0;
      r_owner_dma <= 1'b1;
      r_mar_data  <= '0;
      r_cpu_gnt   <= 1'b0;
      r_cpu_valid <= 1'b0;
      r_dma_gnt   <= 1'b0;
      r_dma_valid <= 1'b0;
      r_dma_done  <= 1'b0;
      r_mar_load  <= 1'b0;
      r_mar_inc   <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_state_nx;
      r_wait      <= w_wait_nx;
      r_remain    <= w_remain_nx;
      r_owner_dma <= w_owner_nx;
      r_mar_data  <= w_mar_data_nx;
      r_cpu_gnt   <= (w_state_nx != S_IDLE) && !w_owner_nx;
      r_dma_gnt   <= (w_state_nx != S_IDLE) && w_owner_nx;
      r_cpu_valid <= w_fire_nx && !w_owner_nx;
      r_dma_valid <= w_fire_nx && w_owner_nx;
      r_mar_inc   <= w_fire_nx && (w_remain_nx != LEN_W'(1));
      r_mar_load  <= (w_state_nx == S_LOAD);
      r_dma_done  <= (w_state_nx == S_DONE) && w_owner_nx;
      r_busy      <= (w_state_nx != S_IDLE);
    end
  end

  assign bus.cpu_gnt   = r_cpu_gnt;
  assign bus.cpu_valid = r_cpu_valid;
  assign bus.dma_gnt   = r_dma_gnt;
  assign bus.dma_valid = r_dma_valid;
  assign bus.dma_done  = r_dma_done;
  assign bus.mar_data  = r_mar_data;
  assign bus.mar_load  = r_mar_load;
  assign bus.mar_inc   = r_mar_inc;
  assign bus.busy      = r_busy;
  assign o_dbg_state   = r_state;

endmodule

// File: tb/tb_mar_access_arbiter.sv
// Directed bench for mar_access_arbiter: one instance at RAM_LAT=1, one at RAM_LAT=3, plus a model of the external MAR.
module tb_mar_access_arbiter;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_BEAT = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  // ctl vector: {cpu_gnt, cpu_valid, dma_gnt, dma_valid, dma_done, mar_load, mar_inc, busy}
  logic [7:0] v_cpu1  [4]  = '{8'h85, 8'hC1, 8'h81, 8'h00};
  logic [7:0] v_dma4  [7]  = '{8'h25, 8'h33, 8'h33, 8'h33, 8'h31, 8'h29, 8'h00};
  logic [7:0] v_lat3  [12] = '{8'h25, 8'h21, 8'h21, 8'h33, 8'h21, 8'h21,
                               8'h33, 8'h21, 8'h21, 8'h31, 8'h29, 8'h00};
  logic [7:0] v_len0  [6]  = '{8'h25, 8'h21, 8'h21, 8'h31, 8'h29, 8'h00};
  logic [15:0] v_mar3 [3]  = '{16'hFFFE, 16'hFFFF, 16'h0000};

  logic       Clk;
  logic       Rst_n;
  logic [1:0] o_state1, o_state3;
  int         n_checks;
  int         n_errors;

  mar_access_arbiter_if #(.ADDR_W(16), .LEN_W(8)) if1 ();
  mar_access_arbiter_if #(.ADDR_W(16), .LEN_W(8)) if3 ();

  mar_access_arbiter #(.ADDR_W(16), .LEN_W(8), .RAM_LAT(1)) dut1 (
    .Clk(Clk), .Rst_n(Rst_n), .bus(if1), .o_dbg_state(o_state1)
  );
  mar_access_arbiter #(.ADDR_W(16), .LEN_W(8), .RAM_LAT(3)) dut3 (
    .Clk(Clk), .Rst_n(Rst_n), .bus(if3), .o_dbg_state(o_state3)
  );

  logic [7:0] ctl1, ctl3;
  assign ctl1 = {if1.cpu_gnt, if1.cpu_valid, if1.dma_gnt, if1.dma_valid,
                 if1.dma_done, if1.mar_load, if1.mar_inc, if1.busy};
  assign ctl3 = {if3.cpu_gnt, if3.cpu_valid, if3.dma_gnt, if3.dma_valid,
                 if3.dma_done, if3.mar_load, if3.mar_inc, if3.busy};

  // External MAR: load wins, otherwise increment; reset does not touch it.
  logic [15:0] mar1 = '0;
  logic [15:0] mar3 = '0;
  always @(posedge Clk) begin
    if (if1.mar_load) mar1 <= if1.mar_data;
    else if (if1.mar_inc) mar1 <= mar1 + 16'd1;
    if (if3.mar_load) mar3 <= if3.mar_data;
    else if (if3.mar_inc) mar3 <= mar3 + 16'd1;
  end

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge Clk);
  endtask

  initial begin
    int beats;
    int grants;
    logic [1:0] prev1, prev2;
    logic exp_dma;
    logic seen;
    n_checks = 0;
    n_errors = 0;
    if1.cpu_req = 0; if1.cpu_addr = '0; if1.dma_req = 0; if1.dma_addr = '0; if1.dma_len = '0;
    if3.cpu_req = 0; if3.cpu_addr = '0; if3.dma_req = 0; if3.dma_addr = '0; if3.dma_len = '0;
    Rst_n = 1'b0;
    repeat (2) tick();
    check_val("rst_ctl1", {24'd0, ctl1}, 32'h0);
    check_val("rst_ctl3", {24'd0, ctl3}, 32'h0);
    check_val("rst_state1", {30'd0, o_state1}, {30'd0, S_IDLE});
    check_val("rst_mar_data", {16'd0, if1.mar_data}, 32'h0);
    Rst_n = 1'b1;
    tick();

    // 1: single CPU access
    if1.cpu_addr = 16'h1234;
    if1.cpu_req  = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      tick();
      if (c == 1) begin
        check_val("t1_mar_data", {16'd0, if1.mar_data}, 32'h1234);
        check_val("t1_state_load", {30'd0, o_state1}, {30'd0, S_LOAD});
        if1.cpu_req  = 1'b0;
        if1.cpu_addr = 16'hDEAD;
      end
      if (c == 2) check_val("t1_mar_held", {16'd0, mar1}, 32'h1234);
      if (c == 3) check_val("t1_state_done", {30'd0, o_state1}, {30'd0, S_DONE});
      check_val($sformatf("t1_ctl_c%0d", c), {24'd0, ctl1}, {24'd0, v_cpu1[c-1]});
    end
    check_val("t1_state_idle", {30'd0, o_state1}, {30'd0, S_IDLE});
    check_val("t1_mar_data_clr", {16'd0, if1.mar_data}, 32'h0);

    // 2: DMA burst of 4 at RAM_LAT=1
    if1.dma_addr = 16'h00F0;
    if1.dma_len  = 8'd4;
    if1.dma_req  = 1'b1;
    beats = 0;
    for (int c = 1; c <= 7; c++) begin
      tick();
      if (c == 1) if1.dma_req = 1'b0;
      check_val($sformatf("t2_ctl_c%0d", c), {24'd0, ctl1}, {24'd0, v_dma4[c-1]});
      if (if1.dma_valid) begin
        check_val($sformatf("t2_mar_b%0d", beats), {16'd0, mar1}, 32'h00F0 + beats);
        beats++;
      end
    end
    check_val("t2_beats", beats, 4);

    // 3: both requesters held; last owner was DMA so CPU goes first
    if1.cpu_addr = 16'h0A00;
    if1.dma_addr = 16'h0B00;
    if1.dma_len  = 8'd2;
    if1.cpu_req  = 1'b1;
    if1.dma_req  = 1'b1;
    grants = 0;
    prev1 = S_IDLE;
    prev2 = S_IDLE;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (if1.mar_load && grants < 4) begin
        exp_dma = (grants % 2) == 1;
        check_val($sformatf("t3_owner_g%0d", grants), {31'd0, if1.dma_gnt}, {31'd0, exp_dma});
        check_val($sformatf("t3_cpu_gnt_g%0d", grants), {31'd0, if1.cpu_gnt}, {31'd0, !exp_dma});
        check_val($sformatf("t3_addr_g%0d", grants), {16'd0, if1.mar_data},
                  exp_dma ? 32'h0B00 : 32'h0A00);
        if (grants > 0)
          check_val($sformatf("t3_gap_g%0d", grants), {28'd0, prev2, prev1}, {28'd0, S_DONE, S_IDLE});
        grants++;
        if (grants == 4) begin
          if1.cpu_req = 1'b0;
          if1.dma_req = 1'b0;
        end
      end
      prev2 = prev1;
      prev1 = o_state1;
    end
    check_val("t3_grants", grants, 4);
    check_val("t3_state_idle", {30'd0, o_state1}, {30'd0, S_IDLE});

    // 4: RAM_LAT=3 burst wrapping past 0xFFFF, then a zero-length burst
    if3.dma_addr = 16'hFFFE;
    if3.dma_len  = 8'd3;
    if3.dma_req  = 1'b1;
    beats = 0;
    for (int c = 1; c <= 12; c++) begin
      tick();
      if (c == 1) if3.dma_req = 1'b0;
      check_val($sformatf("t4_ctl_c%0d", c), {24'd0, ctl3}, {24'd0, v_lat3[c-1]});
      if (if3.dma_valid) begin
        if (beats < 3)
          check_val($sformatf("t4_mar_b%0d", beats), {16'd0, mar3}, {16'd0, v_mar3[beats]});
        beats++;
      end
    end
    check_val("t4_beats", beats, 3);
    if3.dma_addr = 16'h0100;
    if3.dma_len  = 8'd0;
    if3.dma_req  = 1'b1;
    beats = 0;
    for (int c = 1; c <= 6; c++) begin
      tick();
      if (c == 1) if3.dma_req = 1'b0;
      check_val($sformatf("t4z_ctl_c%0d", c), {24'd0, ctl3}, {24'd0, v_len0[c-1]});
      if (if3.dma_valid) begin
        check_val("t4z_mar", {16'd0, mar3}, 32'h0100);
        beats++;
      end
    end
    check_val("t4z_beats", beats, 1);

    // 5: reset during the second beat of an 8-beat burst
    if1.dma_addr = 16'h0200;
    if1.dma_len  = 8'd8;
    if1.dma_req  = 1'b1;
    tick();
    if1.dma_req = 1'b0;
    check_val("t5_ctl_c1", {24'd0, ctl1}, 32'h25);
    tick();
    check_val("t5_ctl_c2", {24'd0, ctl1}, 32'h33);
    tick();
    check_val("t5_ctl_c3", {24'd0, ctl1}, 32'h33);
    Rst_n = 1'b0;
    tick();
    check_val("t5_rst_ctl", {24'd0, ctl1}, 32'h0);
    check_val("t5_rst_state", {30'd0, o_state1}, {30'd0, S_IDLE});
    check_val("t5_rst_mar_data", {16'd0, if1.mar_data}, 32'h0);
    Rst_n = 1'b1;
    seen = 1'b0;
    repeat (4) begin
      tick();
      if (if1.dma_done || if1.dma_valid || if1.busy) seen = 1'b1;
    end
    check_val("t5_silent_abort", {31'd0, seen}, 32'h0);
    if1.cpu_addr = 16'h3333;
    if1.dma_addr = 16'h4444;
    if1.dma_len  = 8'd1;
    if1.cpu_req  = 1'b1;
    if1.dma_req  = 1'b1;
    tick();
    if1.cpu_req = 1'b0;
    if1.dma_req = 1'b0;
    check_val("t5_tie_cpu_gnt", {31'd0, if1.cpu_gnt}, 32'h1);
    check_val("t5_tie_dma_gnt", {31'd0, if1.dma_gnt}, 32'h0);
    check_val("t5_tie_addr", {16'd0, if1.mar_data}, 32'h3333);
    repeat (4) tick();
    check_val("t5_end_idle", {30'd0, o_state1}, {30'd0, S_IDLE});

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
